// File: rtl/msrv32_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_unit_pkg
//  Description : Shared constants for the msrv32 program-counter unit:
//                FSM state encoding, default boot address, PC increment and
//                the JALR-style branch target helper.
//  Revision    : 1.0  initial release
// ============================================================================
package msrv32_pc_unit_pkg;

   // FSM state encoding
   typedef logic [0:0] pc_state_t;
   localparam pc_state_t STATE_BOOT = 1'b0;
   localparam pc_state_t STATE_RUN  = 1'b1;

   // Reset / boot program counter used when the instantiation does not override it
   localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

   // Sequential fetch stride
   localparam logic [31:0] PC_INCREMENT = 32'd4;

   // Branch/jump targets always have bit 0 cleared (JALR semantics)
   function automatic logic [31:0] branch_target(input logic [31:0] sum);
      return {sum[31:1], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_unit_if
//  Description : Redirect/stall inputs and PC outputs of the msrv32 PC unit.
//                'slave' is the PC unit side, 'master' the pipeline side.
//  Revision    : 1.0  initial release
// ============================================================================
interface msrv32_pc_unit_if;
   logic        stall_in;
   logic        branch_taken_in;
   logic [31:0] iadder_in;
   logic        trap_taken_in;
   logic [31:0] trap_address_in;
   logic        mret_in;
   logic [31:0] epc_in;
   logic [31:0] pc_out;
   logic [31:0] pc_plus_4_out;
   logic [31:0] i_addr_out;
   logic        misaligned_instr_out;
   logic        flush_out;

   modport slave (
      input  stall_in, branch_taken_in, iadder_in, trap_taken_in,
             trap_address_in, mret_in, epc_in,
      output pc_out, pc_plus_4_out, i_addr_out, misaligned_instr_out, flush_out
   );

   modport master (
      output stall_in, branch_taken_in, iadder_in, trap_taken_in,
             trap_address_in, mret_in, epc_in,
      input  pc_out, pc_plus_4_out, i_addr_out, misaligned_instr_out, flush_out
   );
endinterface
`default_nettype wire

// File: rtl/msrv32_pc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_mux
//  Description : Fixed-priority next-PC selection: trap, mret, aligned branch,
//                then sequential. Also flags a misaligned branch target.
//  Revision    : 1.0  initial release
// ============================================================================
module msrv32_pc_mux
   import msrv32_pc_unit_pkg::*;
(
   input  wire logic        run_in,
   input  wire logic        trap_taken_in,
   input  wire logic [31:0] trap_address_in,
   input  wire logic        mret_in,
   input  wire logic [31:0] epc_in,
   input  wire logic        branch_taken_in,
   input  wire logic [31:0] iadder_in,
   input  wire logic [31:0] pc_plus_4_in,
   output logic [31:0]      next_pc_out,
   output logic             redirect_out,
   output logic             misaligned_out
);

   // Bit 0 of the adder sum is discarded by the JALR target rule
   logic unused_iadder_bit0;
   assign unused_iadder_bit0 = iadder_in[0];

   // Priority select; a misaligned branch falls back to the sequential path
   always_comb begin
      misaligned_out = run_in & branch_taken_in & iadder_in[1] & ~trap_taken_in & ~mret_in;
      next_pc_out    = pc_plus_4_in;
      redirect_out   = 1'b0;
      if (trap_taken_in) begin
         next_pc_out  = trap_address_in;
         redirect_out = 1'b1;
      end else if (mret_in) begin
         next_pc_out  = epc_in;
         redirect_out = 1'b1;
      end else if (branch_taken_in && !iadder_in[1]) begin
         next_pc_out  = branch_target(iadder_in);
         redirect_out = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/msrv32_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_unit
//  Description : msrv32 program counter unit: BOOT/RUN FSM, PC register and
//                flush register, with zero-cycle fetch address generation.
//  Revision    : 1.0  initial release
// ============================================================================
module msrv32_pc_unit
   import msrv32_pc_unit_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDRESS = DEFAULT_BOOT_ADDRESS
) (
   input  wire logic          clk_in,
   input  wire logic          rst_n_in,
   msrv32_pc_unit_if.slave    bus
);

   pc_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        flush_q, flush_d;
   logic [31:0] pc_plus_4;
   logic [31:0] next_pc;
   logic        redirect;
   logic        misaligned;
   logic        run;

   assign run       = (state_q == STATE_RUN);
   assign pc_plus_4 = pc_q + PC_INCREMENT;

   msrv32_pc_mux u_pc_mux (
      .run_in          (run),
      .trap_taken_in   (bus.trap_taken_in),
      .trap_address_in (bus.trap_address_in),
      .mret_in         (bus.mret_in),
      .epc_in          (bus.epc_in),
      .branch_taken_in (bus.branch_taken_in),
      .iadder_in       (bus.iadder_in),
      .pc_plus_4_in    (pc_plus_4),
      .next_pc_out     (next_pc),
      .redirect_out    (redirect),
      .misaligned_out  (misaligned)
   );

   // State, PC and flush registers with asynchronous active-low reset
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= STATE_BOOT;
         pc_q    <= BOOT_ADDRESS;
         flush_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
      end
   end

   // Next state: BOOT always advances to RUN after one edge
   always_comb begin
      state_d = STATE_RUN;
      if (state_q == STATE_BOOT) state_d = STATE_RUN;
   end

   // Next PC/flush: held under stall, loaded from the mux otherwise
   always_comb begin
      pc_d    = pc_q;
      flush_d = flush_q;
      if (state_q == STATE_BOOT) begin
         pc_d    = BOOT_ADDRESS;
         flush_d = 1'b0;
      end else if (!bus.stall_in) begin
         pc_d    = next_pc;
         flush_d = redirect;
      end
   end

   // Outputs: fetch address follows next_pc unless booting or stalled
   always_comb begin
      bus.i_addr_out = next_pc;
      if (state_q == STATE_BOOT)  bus.i_addr_out = BOOT_ADDRESS;
      else if (bus.stall_in)      bus.i_addr_out = pc_q;
      bus.pc_out               = pc_q;
      bus.pc_plus_4_out        = pc_plus_4;
      bus.flush_out            = flush_q;
      bus.misaligned_instr_out = misaligned;
   end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrv32_pc_unit
//  Description : Directed scoreboard bench for msrv32_pc_unit (two instances:
//                boot address 0 and boot address 0xFFFF_FFFC).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msrv32_pc_unit;

   typedef struct {
      int unsigned sel;
      string       name;
      logic [31:0] pc;
      logic [31:0] iaddr;
      logic        flush;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   checks = 0;
   int   fails  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   msrv32_pc_unit_if ifa();
   msrv32_pc_unit_if ifb();

   msrv32_pc_unit #(.BOOT_ADDRESS(32'h0000_0000)) dut_a (
      .clk_in   (clk),
      .rst_n_in (rst_a),
      .bus      (ifa)
   );

   msrv32_pc_unit #(.BOOT_ADDRESS(32'hFFFF_FFFC)) dut_b (
      .clk_in   (clk),
      .rst_n_in (rst_b),
      .bus      (ifb)
   );

   task automatic chk(input string name, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue its expected outputs
   task automatic drive(input int unsigned sel, input logic rst, input logic stall,
                        input logic br, input logic [31:0] iad,
                        input logic trap, input logic [31:0] taddr,
                        input logic mret, input logic [31:0] epc,
                        input string name, input logic [31:0] e_pc,
                        input logic [31:0] e_iaddr, input logic e_flush, input logic e_mis);
      exp_t e;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         rst_a = rst;
         ifa.stall_in = stall; ifa.branch_taken_in = br; ifa.iadder_in = iad;
         ifa.trap_taken_in = trap; ifa.trap_address_in = taddr;
         ifa.mret_in = mret; ifa.epc_in = epc;
      end else begin
         rst_b = rst;
         ifb.stall_in = stall; ifb.branch_taken_in = br; ifb.iadder_in = iad;
         ifb.trap_taken_in = trap; ifb.trap_address_in = taddr;
         ifb.mret_in = mret; ifb.epc_in = epc;
      end
      e.sel = sel; e.name = name; e.pc = e_pc; e.iaddr = e_iaddr;
      e.flush = e_flush; e.mis = e_mis;
      sb.push_back(e);
   endtask

   // Monitor: pops the queued expectation for each cycle and compares on the falling edge
   initial begin
      exp_t e;
      logic [31:0] a_pc, a_pc4, a_ia;
      logic        a_fl, a_mis;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
               a_pc = ifa.pc_out; a_pc4 = ifa.pc_plus_4_out; a_ia = ifa.i_addr_out;
               a_fl = ifa.flush_out; a_mis = ifa.misaligned_instr_out;
            end else begin
               a_pc = ifb.pc_out; a_pc4 = ifb.pc_plus_4_out; a_ia = ifb.i_addr_out;
               a_fl = ifb.flush_out; a_mis = ifb.misaligned_instr_out;
            end
            chk(e.name, "pc_out", a_pc, e.pc);
            chk(e.name, "pc_plus_4_out", a_pc4, e.pc + 32'd4);
            chk(e.name, "i_addr_out", a_ia, e.iaddr);
            chk(e.name, "flush_out", {31'd0, a_fl}, {31'd0, e.flush});
            chk(e.name, "misaligned", {31'd0, a_mis}, {31'd0, e.mis});
         end
      end
   end

   initial begin
      ifa.stall_in = 0; ifa.branch_taken_in = 0; ifa.iadder_in = 0;
      ifa.trap_taken_in = 0; ifa.trap_address_in = 0; ifa.mret_in = 0; ifa.epc_in = 0;
      ifb.stall_in = 0; ifb.branch_taken_in = 0; ifb.iadder_in = 0;
      ifb.trap_taken_in = 0; ifb.trap_address_in = 0; ifb.mret_in = 0; ifb.epc_in = 0;

      // ---------------- instance A, boot address 0 ----------------
      //     sel rst st br iadder        tr taddr         mr epc       name         pc            iaddr         fl mis
      drive(0, 0, 1, 1, 32'h0000_0002, 1, 32'h0000_0300, 0, 32'h0, "a_reset",    32'h0000_0000, 32'h0000_0000, 1, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "a_boot",     32'h0000_0000, 32'h0000_0000, 1, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "a_run0",     32'h0000_0000, 32'h0000_0004, 0, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "a_run4",     32'h0000_0004, 32'h0000_0008, 0, 0);
      drive(0, 1, 0, 1, 32'h0000_0101, 0, 32'h0,         0, 32'h0, "a_branch",   32'h0000_0008, 32'h0000_0100, 0, 0);
      drive(0, 1, 0, 1, 32'h0000_0106, 0, 32'h0,         0, 32'h0, "a_misalign", 32'h0000_0100, 32'h0000_0104, 1, 1);
      drive(0, 1, 0, 1, 32'h0000_0106, 1, 32'h0000_0200, 1, 32'h40,"a_trap",     32'h0000_0104, 32'h0000_0200, 0, 0);
      drive(0, 1, 1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0, "a_stall1",   32'h0000_0200, 32'h0000_0200, 1, 0);
      drive(0, 1, 1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0, "a_stall2",   32'h0000_0200, 32'h0000_0200, 1, 0);
      drive(0, 1, 1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0, "a_stall3",   32'h0000_0200, 32'h0000_0200, 1, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "a_unstall",  32'h0000_0200, 32'h0000_0204, 1, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h40,"a_mret",     32'h0000_0204, 32'h0000_0040, 0, 0);
      drive(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "a_after_mret",32'h0000_0040,32'h0000_0044, 1, 0);
      drive(0, 1, 1, 1, 32'h0000_0500, 0, 32'h0,         0, 32'h0, "a_stall_br", 32'h0000_0044, 32'h0000_0044, 0, 0);

      // ---------------- instance B, boot address 0xFFFF_FFFC ----------------
      drive(1, 0, 1, 1, 32'h0000_0002, 0, 32'h0,         0, 32'h0, "b_reset",    32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
      drive(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "b_boot",     32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
      drive(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "b_wrap",     32'hFFFF_FFFC, 32'h0000_0000, 0, 0);
      drive(1, 1, 1, 1, 32'h0000_0010, 0, 32'h0,         0, 32'h0, "b_stall1",   32'h0000_0000, 32'h0000_0000, 0, 0);
      drive(1, 1, 1, 1, 32'h0000_0010, 0, 32'h0,         0, 32'h0, "b_stall2",   32'h0000_0000, 32'h0000_0000, 0, 0);
      drive(1, 0, 1, 1, 32'h0000_0010, 0, 32'h0,         0, 32'h0, "b_rst_pulse",32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
      drive(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "b_reboot",   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
      drive(1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0, "b_rerun",    32'hFFFF_FFFC, 32'h0000_0000, 0, 0);

      // Let the monitor drain the scoreboard, bounded
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/msrv32_pc_unit.md
MSRV32_PC_UNIT -- requirements
Module: msrv32_pc_unit

Interface
REQ-001 The module SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000, the reset and boot program counter value.
REQ-002 clk_in  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 stall_in  input  1  pipeline stall, for example instruction bus not ready.
REQ-005 branch_taken_in  input  1  a taken branch or jump this cycle.
REQ-006 iadder_in  input  32  branch or jump target sum from msrv32_immediate_adder.
REQ-007 trap_taken_in  input  1  trap entry request from the CSR unit.
REQ-008 trap_address_in  input  32  trap vector address.
REQ-009 mret_in  input  1  return-from-trap request.
REQ-010 epc_in  input  32  return address for mret.
REQ-011 pc_out  output  32  registered PC of the instruction in the execute stage.
REQ-012 pc_plus_4_out  output  32  pc_out+4, modulo 2^32.
REQ-013 i_addr_out  output  32  combinational next-fetch address to instruction memory.
REQ-014 misaligned_instr_out  output  1  combinational flag: the taken target is not word-aligned.
REQ-015 flush_out  output  1  registered flag: kill the fetched instruction.

Function
REQ-016 The FSM SHALL have two states, BOOT and RUN.
- BOOT SHALL be entered on reset.
- BOOT SHALL move to RUN unconditionally on the first clock edge after reset release.
REQ-017 In BOOT:
- i_addr_out SHALL be BOOT_ADDRESS.
- pc_out SHALL stay at BOOT_ADDRESS.
- flush_out SHALL be 1.
REQ-018 In RUN, next_pc SHALL be selected by fixed priority: trap_taken_in, then mret_in, then valid branch, then sequential.
- trap_taken_in: trap_address_in.
- mret_in: epc_in.
- valid branch: {iadder_in[31:1],1'b0}.
- sequential: pc_plus_4_out.
REQ-019 The branch target SHALL have bit 0 cleared, per JALR.
REQ-020 misaligned_instr_out SHALL be branch_taken_in AND iadder_in[1], with the FSM in RUN, trap_taken_in=0 and mret_in=0.
REQ-021 A misaligned branch SHALL NOT redirect; next_pc SHALL fall back to the sequential path.
REQ-022 A valid branch SHALL be branch_taken_in=1 with misaligned_instr_out=0.
REQ-023 In RUN with stall_in=0, i_addr_out SHALL equal next_pc, and pc_out SHALL load next_pc at the edge (zero-cycle fetch latency, one-cycle PC update).
REQ-024 In RUN with stall_in=1:
- pc_out SHALL hold.
- i_addr_out SHALL equal pc_out.
- flush_out SHALL hold its value.
- All redirect inputs SHALL be ignored; upstream holds requests until the stall clears.
REQ-025 flush_out SHALL be 1 on the cycle after an unstalled edge that took a trap, mret or valid branch, and 0 on the cycle after an unstalled sequential edge.
REQ-026 When trap_taken_in and mret_in are both 1, the trap SHALL win.
REQ-027 When trap_taken_in and a misaligned branch coincide, the trap SHALL win and misaligned_instr_out SHALL be 0.
REQ-028 PC arithmetic SHALL wrap modulo 2^32: 32'hFFFF_FFFC sequential SHALL give 32'h0000_0000, with no flag.

Reset
REQ-029 On rst_n_in=0, asynchronously and regardless of clock or stall:
- state SHALL be BOOT.
- pc_out SHALL be BOOT_ADDRESS.
- pc_plus_4_out SHALL be BOOT_ADDRESS+4.
- flush_out SHALL be 1.
- i_addr_out SHALL be BOOT_ADDRESS.
- misaligned_instr_out SHALL be 0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending request.

Structure
REQ-031 The shared msrv32 package SHALL hold:
- the state encoding (BOOT=1'b0, RUN=1'b1).
- the default boot address constant.
- the PC increment constant 4.
REQ-032 The next-PC priority mux SHALL be a sub-module msrv32_pc_mux; the FSM, PC register and flush register SHALL stay in msrv32_pc_unit.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset then release, 3 unstalled edges -> pc_out=0,0,4,8 and flush_out=1,0,0.
- At pc=8, branch_taken_in=1, iadder_in=32'h0000_0101 -> i_addr_out=32'h100, misaligned_instr_out=0; next cycle pc_out=32'h100, flush_out=1.
- At pc=32'h100, branch_taken_in=1, iadder_in=32'h0000_0106 -> misaligned_instr_out=1, i_addr_out=32'h104; next cycle flush_out=0.
- trap_taken_in=1 with trap_address_in=32'h0000_0200, mret_in=1 with epc_in=32'h40 -> pc_out=32'h200 next cycle.
- stall_in=1 for 3 cycles at pc=32'h200 with branch_taken_in=1 -> pc_out and i_addr_out stay 32'h200; after release, sequential 32'h204.
- BOOT_ADDRESS=32'hFFFF_FFFC, run 2 edges after reset -> pc_out=32'hFFFF_FFFC then 32'h0; rst_n_in pulsed low mid-stall -> immediate pc_out=BOOT_ADDRESS.
